// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader_pkg
// Brief    : Shared types and constants for the byte-serial instruction
//            memory boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package imem_boot_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_e;

endpackage : imem_boot_loader_pkg
`default_nettype wire

// File: rtl/imem_boot_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader_word_packer
// Brief    : Steers incoming bytes into the lanes of a 32-bit word. Lanes not
//            yet written stay zero, so a short final word is zero padded.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader_word_packer
    import imem_boot_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic [CNT_W-1:0]  o_byte_cnt
);

    logic [CNT_W-1:0]  r_byte_cnt;
    logic [WORD_W-1:0] r_word;
    logic [1:0]        w_lane;

    // First byte lands in the top lane for big-endian, bottom lane otherwise.
    assign w_lane = BIG_ENDIAN ? (2'd3 - r_byte_cnt[1:0]) : r_byte_cnt[1:0];

    // Accumulate bytes; clearing empties the word so later padding reads zero.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else if (i_push) begin
            r_word[{w_lane, 3'b000} +: BYTE_W] <= i_byte;
            r_byte_cnt                         <= r_byte_cnt + 1'b1;
        end
    end

    assign o_word     = r_word;
    assign o_byte_cnt = r_byte_cnt;

endmodule : imem_boot_loader_word_packer
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Packs a byte stream into instruction words, writes them to
//            instruction memory from address 0, and releases the core once
//            the whole image is loaded. Overrunning capacity is fatal.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              core_run,
    output logic              done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] C_ADDR_MAX = '1;

    loader_state_e     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count;
    logic              r_full;
    logic              r_last;
    logic              r_in_ready;
    logic              r_imem_we;
    logic              r_core_run;
    logic              r_done;
    logic              r_overflow;

    logic              w_xfer;
    logic              w_push;
    logic              w_clear;
    logic              w_word_end;
    logic [CNT_W-1:0]  w_byte_cnt;
    logic [WORD_W-1:0] w_word;

    // in_ready is only ever high in LOAD, so it fully qualifies a transfer.
    assign w_xfer     = in_valid && r_in_ready;
    // Once the memory is full every further byte is dropped, never packed.
    assign w_push     = w_xfer && !r_full;
    assign w_word_end = (w_byte_cnt == 3'd3) || in_last;
    // Packer starts empty for a new load and after each word is committed.
    assign w_clear    = (r_state == ST_WRITE) || ((r_state == ST_IDLE) && start);

    imem_boot_loader_word_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_word_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_push     (w_push),
        .i_byte     (in_data),
        .o_word     (w_word),
        .o_byte_cnt (w_byte_cnt)
    );

    // Loader FSM with address counter, full flag and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_word_count <= '0;
            r_full       <= 1'b0;
            r_last       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_core_run   <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_addr       <= '0;
                        r_word_count <= '0;
                        r_full       <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (r_full) begin
                            r_state    <= ST_ERROR;
                            r_in_ready <= 1'b0;
                            r_overflow <= 1'b1;
                        end else if (w_word_end) begin
                            r_state    <= ST_WRITE;
                            r_in_ready <= 1'b0;
                            r_imem_we  <= 1'b1;
                            r_last     <= in_last;
                        end
                    end
                end
                ST_WRITE: begin
                    // Address wraps after the last slot; full keeps it from being reused.
                    r_addr       <= r_addr + 1'b1;
                    r_word_count <= r_word_count + 1'b1;
                    if (r_addr == C_ADDR_MAX) begin
                        r_full <= 1'b1;
                    end
                    if (r_last) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_core_run <= 1'b1;
                    end else begin
                        r_state    <= ST_LOAD;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign word_count = r_word_count;
    assign core_run   = r_core_run;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule : imem_boot_loader
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Directed self-checking bench. Three loaders share one stimulus
//            stream: 8-bit address big-endian (main), 8-bit little-endian,
//            and a 2-bit address big-endian instance for overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;

    logic        m_ready, m_we, m_run, m_done, m_ovf;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [8:0]  m_wc;

    logic        l_ready, l_we, l_run, l_done, l_ovf;
    logic [7:0]  l_addr;
    logic [31:0] l_wdata;
    logic [8:0]  l_wc;

    logic        s_ready, s_we, s_run, s_done, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_wc;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  q_m_addr[$];
    logic [31:0] q_m_data[$];
    logic [31:0] q_l_data[$];
    logic [1:0]  q_s_addr[$];

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(m_ready),
        .in_data(in_data), .in_last(in_last), .imem_we(m_we), .imem_addr(m_addr),
        .imem_wdata(m_wdata), .word_count(m_wc), .core_run(m_run), .done(m_done),
        .overflow(m_ovf)
    );

    imem_boot_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(l_ready),
        .in_data(in_data), .in_last(in_last), .imem_we(l_we), .imem_addr(l_addr),
        .imem_wdata(l_wdata), .word_count(l_wc), .core_run(l_run), .done(l_done),
        .overflow(l_ovf)
    );

    imem_boot_loader #(.ADDR_W(2), .BIG_ENDIAN(1'b1)) dut_sm (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_ready),
        .in_data(in_data), .in_last(in_last), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .word_count(s_wc), .core_run(s_run), .done(s_done),
        .overflow(s_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every memory write seen on each instance.
    always @(negedge clk) begin
        if (m_we) begin
            q_m_addr.push_back(m_addr);
            q_m_data.push_back(m_wdata);
            check_eq("ready_in_write", {63'd0, m_ready}, 64'd0);
        end
        if (l_we) q_l_data.push_back(l_wdata);
        if (s_we) q_s_addr.push_back(s_addr);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q_m_addr.delete(); q_m_data.delete(); q_l_data.delete(); q_s_addr.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = b; in_last = last;
        while (!m_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!m_ready) check_eq("ready_wait", {63'd0, m_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last, input int max_gap);
        for (int k = 0; k < 4; k++)
            send_byte(w[31-8*k -: 8], last && (k == 3), $urandom_range(0, max_gap));
    endtask

    task automatic wait_done();
        int t = 0;
        while (!m_done && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_wait", {63'd0, m_done}, 64'd1);
    endtask

    logic [31:0] img [3] = '{32'h20090005, 32'h200A0007, 32'h012A8020};

    initial begin
        // Reset state: every output of the main instance is zero.
        @(negedge clk); @(negedge clk);
        check_eq("reset_outputs", {m_ready, m_we, m_addr, m_wdata, m_wc, m_run, m_done, m_ovf}, 64'd0);
        rst = 1'b0;

        // 1: single word with in_last.
        pulse_start();
        send_word(32'h20090005, 1'b1, 0);
        wait_done();
        check_eq("t1_nwrites", q_m_addr.size(), 1);
        check_eq("t1_addr", q_m_addr[0], 0);
        check_eq("t1_data", q_m_data[0], 32'h20090005);
        check_eq("t1_le_data", q_l_data[0], 32'h05000920);
        check_eq("t1_wcount", m_wc, 1);
        check_eq("t1_run", {m_run, m_done, m_ovf}, 3'b110);

        // 6b: start in DONE is ignored.
        pulse_start();
        repeat (3) @(negedge clk);
        check_eq("t6_done_addr", m_addr, 1);
        check_eq("t6_done_wc", m_wc, 1);
        check_eq("t6_done_nwrites", q_m_addr.size(), 1);
        check_eq("t6_done_state", {m_run, m_done, m_ready}, 3'b110);

        // 2: three words with random valid gaps.
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(img[i], i == 2, 2);
        wait_done();
        check_eq("t2_nwrites", q_m_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_addr", q_m_addr[i], i);
            check_eq("t2_data", q_m_data[i], img[i]);
        end
        check_eq("t2_wcount", m_wc, 3);

        // 3: partial word padded with zeros.
        do_reset();
        pulse_start();
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b1, 1);
        wait_done();
        check_eq("t3_be_data", q_m_data[0], 32'hAABB0000);
        check_eq("t3_le_data", q_l_data[0], 32'h0000BBAA);
        check_eq("t3_wcount", m_wc, 1);

        // 5 + 6a: start in LOAD ignored, reset mid-word discards it.
        do_reset();
        pulse_start();
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        pulse_start();
        repeat (2) @(negedge clk);
        check_eq("t6_load_addr", m_addr, 0);
        check_eq("t6_load_wc", m_wc, 0);
        check_eq("t6_load_ready", {63'd0, m_ready}, 64'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_outputs", {m_ready, m_we, m_addr, m_wdata, m_wc, m_run, m_done, m_ovf}, 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t5_no_write", q_m_addr.size(), 0);
        pulse_start();
        send_word(32'hDEADBEEF, 1'b1, 0);
        wait_done();
        check_eq("t5_reload_addr", q_m_addr[0], 0);
        check_eq("t5_reload_data", q_m_data[0], 32'hDEADBEEF);

        // 4: five words into a four-word memory.
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) send_word(32'h01020304 + i, i == 4, 0);
        wait_done();
        check_eq("t4_sm_nwrites", q_s_addr.size(), 4);
        for (int i = 0; i < 4; i++) check_eq("t4_sm_addr", q_s_addr[i], i);
        check_eq("t4_sm_flags", {s_ovf, s_run, s_done, s_ready}, 4'b1000);
        check_eq("t4_sm_wcount", s_wc, 4);
        check_eq("t4_main_nwrites", q_m_addr.size(), 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_imem_boot_loader
`default_nettype wire
